// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter: FSM states, line levels
// and a frame-length helper.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Serial bit periods per frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int width, input bit parity);
    return width + 2 + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// DIV-cycle bit divider: bit_end pulses on the last cycle of each serial bit.
// The count restarts from zero on clear so every frame begins on a bit boundary.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign bit_end = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (en)      cnt <= bit_end ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/serial_tx.sv
// Framed LSB-first parallel-to-serial transmitter, one bit every DIV clocks.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             Load,
  output logic             Ready,
  output logic             Busy,
  output logic             D
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic             accept, bit_end, d_nxt;

  assign accept = Load && (state == IDLE);

  bit_timer #(.DIV(DIV)) u_timer (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (accept),
    .en      (state != IDLE),
    .bit_end (bit_end)
  );

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken from the word at capture time, not from the shifting copy.
  logic par;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       par <= 1'b0;
    else if (accept) par <= ^Data;
  end
`endif

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE:  if (accept) begin
               state_nxt = START;
               shift_nxt = Data;
               bcnt_nxt  = '0;
             end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end) begin
               if (bcnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                 state_nxt = PARITY;
`else
                 state_nxt = STOP;
`endif
               end else begin
                 shift_nxt = shift >> 1;
                 bcnt_nxt  = bcnt + 1'b1;
               end
             end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Line level is derived from the next state so D is a clean register output.
    d_nxt = IDLE_LEVEL;
    case (state_nxt)
      START:   d_nxt = START_LEVEL;
      DATA:    d_nxt = shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  d_nxt = par;
`endif
      STOP:    d_nxt = STOP_LEVEL;
      default: d_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      shift <= '0;
      bcnt  <= '0;
      D     <= IDLE_LEVEL;
      Ready <= 1'b1;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
      bcnt  <= bcnt_nxt;
      D     <= d_nxt;
      Ready <= (state_nxt == IDLE);
      Busy  <= (state_nxt != IDLE);
    end
  end

endmodule
